// File: rtl/piece_sequencer.sv
// rtl/piece_sequencer.sv - preview queue that turns the random shape stream into issued pieces
// Optional no-repeat reroll filter: define PIECE_SEQ_NOREPEAT_EN.
module piece_sequencer #(
  parameter int DEPTH      = 4,
  parameter int MAX_REROLL = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 rnd_in,
  input  logic                       flush,
  input  logic                       req,
  output logic                       piece_valid,
  output logic [1:0]                 piece,
  output logic [1:0]                 next_piece,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  generate
    if (DEPTH < 2 || DEPTH > 8 || MAX_REROLL < 1 || MAX_REROLL > 7) begin : g_bad_param
      $error("piece_sequencer: DEPTH must be 2..8 and MAX_REROLL 1..7");
    end
  endgenerate

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] count_nxt;
  logic          pending;
  logic          full;
  logic          run;
  logic          accept;
  logic          enq;
  logic          issue;

  // A request that found the queue empty is remembered as the WAIT state.
  assign pending = (state == ST_WAIT);
  assign full    = (count == CNT_FULL);
  assign run     = !reset && !flush;
  assign enq     = run && !full && accept;
  assign issue   = run && (req || pending) && (count != '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef PIECE_SEQ_NOREPEAT_EN
  localparam int RW = $clog2(MAX_REROLL + 1);
  localparam logic [RW-1:0] REROLL_MAX = RW'(MAX_REROLL);

  logic [1:0]    last_enq;
  logic          has_last;
  logic [RW-1:0] reroll_cnt;

  // After MAX_REROLL rejections the repeat is let through so the queue cannot starve.
  assign accept = !has_last || (rnd_in != last_enq) || (reroll_cnt == REROLL_MAX);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      last_enq   <= 2'd0;
      has_last   <= 1'b0;
      reroll_cnt <= '0;
    end else if (enq) begin
      last_enq   <= rnd_in;
      has_last   <= 1'b1;
      reroll_cnt <= '0;
    end else if (!full) begin
      reroll_cnt <= reroll_cnt + 1'b1;
    end
  end
`else
  assign accept = 1'b1;
`endif

  always_comb begin
    count_nxt = count;
    case ({enq, issue})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (issue) begin
      state_nxt = (count_nxt != '0) ? ST_READY : ST_EMPTY;
    end else if (pending || (req && count == '0)) begin
      state_nxt = ST_WAIT;
    end else begin
      state_nxt = (count_nxt != '0) ? ST_READY : ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      state       <= ST_EMPTY;
      piece_valid <= 1'b0;
      piece       <= 2'd0;
    end else begin
      count       <= count_nxt;
      state       <= state_nxt;
      piece_valid <= issue;
      if (enq) begin
        tail <= ptr_inc(tail);
      end
      if (issue) begin
        piece <= mem[head];
        head  <= ptr_inc(head);
      end
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= rnd_in;
    end
  end

  assign next_piece = (count != '0) ? mem[head] : 2'd0;

endmodule

// File: tb/tb_piece_sequencer.sv
// tb/tb_piece_sequencer.sv - directed self-checking bench for piece_sequencer
module tb_piece_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       req = 1'b0;
  logic [1:0] rnd_in = 2'd0;
  logic       piece_valid;
  logic [1:0] piece;
  logic [1:0] next_piece;
  logic [2:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  piece_sequencer #(.DEPTH(4), .MAX_REROLL(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .rnd_in      (rnd_in),
    .flush       (flush),
    .req         (req),
    .piece_valid (piece_valid),
    .piece       (piece),
    .next_piece  (next_piece),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

`ifdef PIECE_SEQ_NOREPEAT_EN
  localparam int NOREP = 1;
`else
  localparam int NOREP = 0;
`endif

  int exp_cnt4_def [5] = '{1, 2, 3, 4, 4};
  int exp_cnt4_nr  [5] = '{1, 1, 1, 1, 2};

  initial begin
    // reset state
    step;
    step;
    check_value("rst_valid", {7'd0, piece_valid}, 8'd0);
    check_value("rst_piece", {6'd0, piece}, 8'd0);
    check_value("rst_next", {6'd0, next_piece}, 8'd0);
    check_value("rst_count", {5'd0, count}, 8'd0);

    // fill from empty, no requests
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rnd_in = 2'(i % 4);
      step;
      check_value("fill_count", {5'd0, count}, 8'((i < 3) ? i + 1 : 4));
      check_value("fill_next", {6'd0, next_piece}, 8'd0);
    end

    // one request from a full queue
    rnd_in = 2'd1;
    req = 1'b1;
    step;
    req = 1'b0;
    check_value("deq_valid", {7'd0, piece_valid}, 8'd1);
    check_value("deq_piece", {6'd0, piece}, 8'd0);
    check_value("deq_next", {6'd0, next_piece}, 8'd1);
    check_value("deq_count", {5'd0, count}, 8'd3);
    step;
    check_value("deq_pulse_end", {7'd0, piece_valid}, 8'd0);
    check_value("deq_piece_hold", {6'd0, piece}, 8'd0);
    check_value("deq_refill", {5'd0, count}, 8'd4);

    // request while empty goes through WAIT
    reset = 1'b1;
    rnd_in = 2'd3;
    step;
    reset = 1'b0;
    req = 1'b1;
    check_value("wait_rst_count", {5'd0, count}, 8'd0);
    step;
    req = 1'b0;
    check_value("wait_count", {5'd0, count}, 8'd1);
    check_value("wait_valid", {7'd0, piece_valid}, 8'd0);
    check_value("wait_next", {6'd0, next_piece}, 8'd3);
    step;
    check_value("wait_issue_valid", {7'd0, piece_valid}, 8'd1);
    check_value("wait_issue_piece", {6'd0, piece}, 8'd3);
    check_value("wait_issue_count", {5'd0, count}, 8'(NOREP ? 0 : 1));
    step;
    check_value("wait_after_valid", {7'd0, piece_valid}, 8'd0);
    check_value("wait_after_piece", {6'd0, piece}, 8'd3);
    check_value("wait_after_count", {5'd0, count}, 8'(NOREP ? 0 : 2));

    // constant input stream from empty
    reset = 1'b1;
    step;
    reset = 1'b0;
    rnd_in = 2'd2;
    for (int i = 0; i < 5; i++) begin
      step;
      check_value("hold2_count", {5'd0, count}, 8'(NOREP ? exp_cnt4_nr[i] : exp_cnt4_def[i]));
      check_value("hold2_next", {6'd0, next_piece}, 8'd2);
    end

    // flush during WAIT drops the pending request
    reset = 1'b1;
    step;
    reset = 1'b0;
    req = 1'b1;
    step;
    req = 1'b0;
    check_value("fl_wait_count", {5'd0, count}, 8'd1);
    flush = 1'b1;
    rnd_in = 2'd1;
    step;
    flush = 1'b0;
    check_value("fl_count", {5'd0, count}, 8'd0);
    check_value("fl_valid", {7'd0, piece_valid}, 8'd0);
    check_value("fl_next", {6'd0, next_piece}, 8'd0);
    check_value("fl_piece", {6'd0, piece}, 8'd0);
    step;
    check_value("fl_refill_count", {5'd0, count}, 8'd1);
    check_value("fl_refill_next", {6'd0, next_piece}, 8'd1);
    check_value("fl_refill_valid", {7'd0, piece_valid}, 8'd0);
    step;
    check_value("fl_no_issue", {7'd0, piece_valid}, 8'd0);

    // full queue: issue once, then req together with reset
    for (int i = 0; i < 4; i++) begin
      rnd_in = 2'(i);
      step;
    end
    check_value("rr_full", {5'd0, count}, 8'd4);
    rnd_in = 2'd0;
    req = 1'b1;
    step;
    req = 1'b0;
    check_value("rr_pre_valid", {7'd0, piece_valid}, 8'd1);
    check_value("rr_pre_piece", {6'd0, piece}, 8'd1);
    step;
    check_value("rr_pre_refill", {5'd0, count}, 8'd4);
    req = 1'b1;
    reset = 1'b1;
    step;
    req = 1'b0;
    reset = 1'b0;
    check_value("rr_valid", {7'd0, piece_valid}, 8'd0);
    check_value("rr_piece", {6'd0, piece}, 8'd0);
    check_value("rr_count", {5'd0, count}, 8'd0);
    check_value("rr_next", {6'd0, next_piece}, 8'd0);

    // full queue: req together with flush
    for (int i = 0; i < 4; i++) begin
      rnd_in = 2'(i);
      step;
    end
    check_value("rf_full", {5'd0, count}, 8'd4);
    req = 1'b1;
    flush = 1'b1;
    step;
    req = 1'b0;
    flush = 1'b0;
    check_value("rf_valid", {7'd0, piece_valid}, 8'd0);
    check_value("rf_count", {5'd0, count}, 8'd0);
    check_value("rf_next", {6'd0, next_piece}, 8'd0);
    step;
    check_value("rf_no_issue", {7'd0, piece_valid}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
